// File: rtl/bsr_pkg.sv
// bsr_pkg: shared definitions for the bitstream bit reader.
//   - input-side state of the byte stuffing filter (DATA, FF, MARK)
//   - the marker prefix byte (0xFF) and the stuffing byte (0x00)
//   - default parameter values for bs_bit_reader
package bsr_pkg;

    localparam int BSR_MAX_BITS = 16;
    localparam int BSR_LEN_W    = 5;
    localparam int BSR_BUF_W    = 32;

    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_FF   = 2'd1,
        ST_MARK = 2'd2
    } in_state_e;

endpackage

// File: rtl/bsr_stuff_filter.sv
// bsr_stuff_filter: byte-in/byte-out valid/ready stage that removes 0xFF00
// byte stuffing and detects markers (0xFF followed by a byte other than
// 0x00 or 0xFF). A detected marker stalls the input until marker_clr.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   byte_in/byte_vld/byte_rdy  upstream byte stream
//   out_byte/out_vld         downstream byte; out_vld is a completed insert
//   out_rdy                  downstream has room for one byte
//   marker_clr               pulse: leave MARK, resume input
//   marker_vld, marker_code  marker stall flag and marker's second byte
module bsr_stuff_filter
    import bsr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    output logic       byte_rdy,
    output logic [7:0] out_byte,
    output logic       out_vld,
    input  logic       out_rdy,
    input  logic       marker_clr,
    output logic       marker_vld,
    output logic [7:0] marker_code
);

    in_state_e  state;
    in_state_e  state_nx;
    logic       accept;
    logic       enter_mark;

    // Upstream handshake follows the downstream room directly, so a byte
    // that will be dropped (0xFF prefix, fill byte) still costs one slot
    // of readiness but never an insert.
    assign byte_rdy   = out_rdy & (state != ST_MARK);
    assign accept     = byte_vld & byte_rdy;
    assign marker_vld = (state == ST_MARK);

    always_comb begin
        state_nx   = state;
        out_vld    = 1'b0;
        out_byte   = byte_in;
        enter_mark = 1'b0;
        case (state)
            ST_DATA: begin
                if (accept) begin
                    if (byte_in == MARKER_PREFIX) begin
                        state_nx = ST_FF;
                    end else begin
                        out_vld = 1'b1;
                    end
                end
            end
            ST_FF: begin
                if (accept) begin
                    if (byte_in == STUFF_BYTE) begin
                        out_vld  = 1'b1;
                        out_byte = MARKER_PREFIX;
                        state_nx = ST_DATA;
                    end else if (byte_in != MARKER_PREFIX) begin
                        state_nx   = ST_MARK;
                        enter_mark = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (marker_clr) begin
                    state_nx = ST_DATA;
                end
            end
            default: begin
                state_nx = ST_DATA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_DATA;
            marker_code <= 8'h00;
        end else begin
            state <= state_nx;
            if (enter_mark) begin
                marker_code <= byte_in;
            end
        end
    end

endmodule

// File: rtl/bs_bit_reader.sv
// bs_bit_reader: drains bytes from the upstream FIFO into an MSB-aligned bit
// buffer and serves 0..MAX_BITS-bit fields, MSB-first, right-aligned in
// bits_out, one field per cycle with one cycle of latency.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   byte_in/byte_vld/byte_rdy     upstream byte stream
//   req_len/req_vld/req_rdy       field request
//   align_req                     pulse: drop bits up to next byte boundary
//   bits_out/bits_vld/bits_rdy    field result
//   bit_cnt                       valid bits currently buffered
//   marker_vld/marker_code/marker_clr  marker stall and release
//
// Build option: define BSR_STUFF_REMOVE_EN to insert bsr_stuff_filter in the
// byte path (0xFF00 unstuffing, marker detection). Without it bytes are
// inserted verbatim and marker_vld/marker_code are tied to zero.
module bs_bit_reader
    import bsr_pkg::*;
#(
    parameter int MAX_BITS = BSR_MAX_BITS,
    parameter int LEN_W    = BSR_LEN_W,
    parameter int BUF_W    = BSR_BUF_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             byte_in,
    input  logic                   byte_vld,
    output logic                   byte_rdy,
    input  logic [LEN_W-1:0]       req_len,
    input  logic                   req_vld,
    output logic                   req_rdy,
    input  logic                   align_req,
    output logic [MAX_BITS-1:0]    bits_out,
    output logic                   bits_vld,
    input  logic                   bits_rdy,
    output logic [$clog2(BUF_W):0] bit_cnt,
    output logic                   marker_vld,
    output logic [7:0]             marker_code,
    input  logic                   marker_clr
);

    localparam int CNT_W = $clog2(BUF_W) + 1;

    // Top n bits of the buffer, right-aligned; n = 0 yields zero.
    function automatic logic [MAX_BITS-1:0] extract_field(
        input logic [BUF_W-1:0] b,
        input logic [LEN_W-1:0] n
    );
        logic [BUF_W-1:0] t;
        if (n == '0) begin
            t = '0;
        end else begin
            t = b >> (BUF_W - int'(n));
        end
        return t[MAX_BITS-1:0];
    endfunction

    logic [BUF_W-1:0]    bit_buf;
    logic [BUF_W-1:0]    buf_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_after;
    logic [CNT_W-1:0]    cnt_nx;
    logic [CNT_W-1:0]    req_len_c;
    logic [CNT_W-1:0]    consume_n;
    logic [2:0]          offset;
    logic [2:0]          offset_nx;
    logic [2:0]          align_bits;
    logic                space_ok;
    logic                req_fire;
    logic                ins_vld;
    logic [7:0]          ins_byte;
    logic [MAX_BITS-1:0] bits_p1;
    logic                vld_p1;

    // Room check uses the current count only, so an accepted byte always
    // fits even if nothing is consumed in the same cycle.
    assign space_ok = (cnt <= CNT_W'(BUF_W - 8));

`ifdef BSR_STUFF_REMOVE_EN
    bsr_stuff_filter u_stuff_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_in     (byte_in),
        .byte_vld    (byte_vld),
        .byte_rdy    (byte_rdy),
        .out_byte    (ins_byte),
        .out_vld     (ins_vld),
        .out_rdy     (space_ok),
        .marker_clr  (marker_clr),
        .marker_vld  (marker_vld),
        .marker_code (marker_code)
    );
`else
    logic unused_marker_clr;
    assign unused_marker_clr = marker_clr;
    assign byte_rdy    = space_ok;
    assign ins_vld     = byte_vld & space_ok;
    assign ins_byte    = byte_in;
    assign marker_vld  = 1'b0;
    assign marker_code = 8'h00;
`endif

    assign req_len_c  = CNT_W'(req_len);
    // Buffered bit count is always a multiple of 8 minus offset, so the
    // bits to the next boundary are always present.
    assign align_bits = 3'd0 - offset;

    assign req_rdy  = (cnt >= req_len_c) & (!vld_p1 | bits_rdy) & !align_req;
    assign req_fire = req_vld & req_rdy;

    always_comb begin
        consume_n = '0;
        offset_nx = offset;
        if (req_fire) begin
            consume_n = req_len_c;
            offset_nx = offset + req_len[2:0];
        end else if (align_req) begin
            consume_n = CNT_W'(align_bits);
            offset_nx = 3'd0;
        end
        cnt_after = cnt - consume_n;
        cnt_nx    = cnt_after + (ins_vld ? CNT_W'(8) : CNT_W'(0));
        // New byte lands just below the bits that survive this cycle's consume.
        buf_nx    = bit_buf << consume_n;
        if (ins_vld) begin
            buf_nx = buf_nx | ({ins_byte, {(BUF_W-8){1'b0}}} >> cnt_after);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf <= '0;
            cnt     <= '0;
            offset  <= 3'd0;
        end else begin
            bit_buf <= buf_nx;
            cnt     <= cnt_nx;
            offset  <= offset_nx;
        end
    end

    // ---- stage p1: field result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (req_fire) begin
            bits_p1 <= extract_field(bit_buf, req_len);
            vld_p1  <= 1'b1;
        end else if (bits_rdy) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bits_out = bits_p1;
    assign bits_vld = vld_p1;
    assign bit_cnt  = cnt;

    a_req_len_legal : assert property (
        @(posedge clk) disable iff (!rst_n) req_vld |-> (req_len <= LEN_W'(MAX_BITS))
    );

endmodule
